// File: rtl/alu_display_ctrl_if.sv
// Bundles the switch inputs and result/display outputs of alu_display_ctrl.
//   X, Y       : operands (WIDTH bits)
//   M          : opcode
//   Control    : capture strobe, asynchronous to the clock
//   Disp_sel   : 0 = show Result, 1 = show captured {X,Y}
//   Result     : registered ALU result (2*WIDTH bits)
//   Carry/Zero/Err/Valid : result flags, Valid is a one-cycle update pulse
//   Anode_Activate : active-low one-cold digit enables
//   LED_out    : active-low segments, bit6 = a .. bit0 = g
interface alu_display_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 8
);
  logic [WIDTH-1:0]   X;
  logic [WIDTH-1:0]   Y;
  logic [3:0]         M;
  logic               Control;
  logic               Disp_sel;
  logic [2*WIDTH-1:0] Result;
  logic               Carry;
  logic               Zero;
  logic               Err;
  logic               Valid;
  logic [DIGITS-1:0]  Anode_Activate;
  logic [6:0]         LED_out;

  modport master (
    output X, Y, M, Control, Disp_sel,
    input  Result, Carry, Zero, Err, Valid, Anode_Activate, LED_out
  );

  modport slave (
    input  X, Y, M, Control, Disp_sel,
    output Result, Carry, Zero, Err, Valid, Anode_Activate, LED_out
  );
endinterface

// File: rtl/alu_display_ctrl.sv
// Parametrised ALU with registered result and a time-multiplexed hex
// 7-segment driver for a common-anode display.
//   clock_100Mhz : single clock, rising edge
//   reset        : synchronous, active-low
//   bus          : alu_display_ctrl_if slave (operands, opcode, strobe,
//                  display select in; result, flags, anodes, segments out)
// A rising edge of the synchronised Control strobe latches X/Y/M; the
// result and flags appear one cycle later together with a Valid pulse.
module alu_display_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clock_100Mhz,
  input  logic               reset,
  alu_display_ctrl_if.slave  bus
);

  localparam int RW      = 2 * WIDTH;
  localparam int SH_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IDX_W   = $clog2(DIGITS);
  localparam int CNT_W   = $clog2(REFRESH_DIV);
  localparam int NIBBLES = RW / 4;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // Stage p0..p2: two-flop synchroniser plus one history flop for edge detect
  logic sync_p0, sync_p1, sync_p2;
  logic cap_p1;

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= bus.Control;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign cap_p1 = sync_p1 & ~sync_p2;

  // Stage p2: operand capture
  logic [WIDTH-1:0] a_p2, b_p2;
  logic [3:0]       op_p2;
  logic             vld_p2;

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      a_p2   <= '0;
      b_p2   <= '0;
      op_p2  <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= cap_p1;
      if (cap_p1) begin
        a_p2  <= bus.X;
        b_p2  <= bus.Y;
        op_p2 <= bus.M;
      end
    end
  end

  // ALU on the latched operands; intermediates are WIDTH wide so that
  // SUB/NOT/SHL wrap at 2^WIDTH before zero-extension to RW.
  logic [RW-1:0]    alu_res;
  logic             alu_carry, alu_err;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] narrow;
  logic [SH_W-1:0]  shamt;

  always_comb begin
    sum       = {1'b0, a_p2} + {1'b0, b_p2};
    shamt     = b_p2[SH_W-1:0];
    narrow    = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op_p2)
      4'd0: begin
        alu_res   = RW'(sum);
        alu_carry = sum[WIDTH];
      end
      4'd1: begin
        narrow    = a_p2 - b_p2;
        alu_res   = RW'(narrow);
        alu_carry = (a_p2 < b_p2);
      end
      4'd2: alu_res = RW'(a_p2) * RW'(b_p2);
      4'd3: begin narrow = a_p2 & b_p2;      alu_res = RW'(narrow); end
      4'd4: begin narrow = a_p2 | b_p2;      alu_res = RW'(narrow); end
      4'd5: begin narrow = a_p2 ^ b_p2;      alu_res = RW'(narrow); end
      4'd6: begin narrow = ~a_p2;            alu_res = RW'(narrow); end
      4'd7: begin narrow = a_p2 << shamt;    alu_res = RW'(narrow); end
      4'd8: begin narrow = a_p2 >> shamt;    alu_res = RW'(narrow); end
      4'd9: alu_res = RW'({a_p2 < b_p2, a_p2 == b_p2, a_p2 > b_p2});
      default: alu_err = 1'b1;
    endcase
  end

  // Stage p3: registered result and flags
  logic [RW-1:0] res_p3;
  logic          carry_p3, zero_p3, err_p3, vld_p3;

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      res_p3   <= '0;
      carry_p3 <= 1'b0;
      zero_p3  <= 1'b0;
      err_p3   <= 1'b0;
      vld_p3   <= 1'b0;
    end else begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        res_p3   <= alu_res;
        carry_p3 <= alu_carry;
        zero_p3  <= (alu_res == '0);
        err_p3   <= alu_err;
      end
    end
  end

  assign bus.Result = res_p3;
  assign bus.Carry  = carry_p3;
  assign bus.Zero   = zero_p3;
  assign bus.Err    = err_p3;
  assign bus.Valid  = vld_p3;

  // Scan timing: prescaler wrap advances the digit index
  logic [CNT_W-1:0] pre_cnt;
  logic [IDX_W-1:0] idx;
  logic             wrap;

  assign wrap = (pre_cnt == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else if (wrap) begin
      pre_cnt <= '0;
      idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      pre_cnt <= pre_cnt + CNT_W'(1);
    end
  end

  // Digit selection; anodes and segments are registered together so the
  // enable and its pattern always change on the same edge.
  logic [RW-1:0]         src;
  logic [DIGITS*4-1:0]   src_ext;
  logic [3:0]            nib;
  logic [6:0]            seg_nxt;
  logic [DIGITS-1:0]     an_nxt;
  logic [6:0]            seg_p1;
  logic [DIGITS-1:0]     an_p1;

  always_comb begin
    src     = bus.Disp_sel ? {a_p2, b_p2} : res_p3;
    src_ext = (DIGITS*4)'(src);
    nib     = src_ext[idx*4 +: 4];
    seg_nxt = (int'(idx) < NIBBLES) ? hex_font(nib) : 7'h7F;
    an_nxt  = ~(DIGITS'(1) << idx);
  end

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      an_p1  <= '1;
      seg_p1 <= 7'h7F;
    end else begin
      an_p1  <= an_nxt;
      seg_p1 <= seg_nxt;
    end
  end

  assign bus.Anode_Activate = an_p1;
  assign bus.LED_out        = seg_p1;

endmodule

// File: tb/tb_alu_display_ctrl.sv
module tb_alu_display_ctrl;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 8;
  localparam int RDIV   = 4;

  localparam logic [6:0] FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_display_ctrl_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  alu_display_ctrl #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(RDIV)
  ) dut (
    .clock_100Mhz (clk),
    .reset        (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU written from the opcode table with integer arithmetic.
  function automatic void ref_alu(input int x, input int y, input int m,
                                  output int r, output int c, output int e);
    r = 0; c = 0; e = 0;
    case (m)
      0: begin r = x + y; c = (x + y > 255) ? 1 : 0; end
      1: begin r = (x - y + 256) % 256; c = (x < y) ? 1 : 0; end
      2: r = x * y;
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: r = 255 - x;
      7: r = (x * (1 << (y % 8))) % 256;
      8: r = x / (1 << (y % 8));
      9: r = ((x < y) ? 4 : 0) + ((x == y) ? 2 : 0) + ((x > y) ? 1 : 0);
      default: e = 1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int x, input int y, input int m);
    int r, c, e;
    ref_alu(x, y, m, r, c, e);
    check({tag, "_result"}, 32'(bus.Result), r);
    check({tag, "_carry"},  32'(bus.Carry),  c);
    check({tag, "_zero"},   32'(bus.Zero),   (r == 0) ? 1 : 0);
    check({tag, "_err"},    32'(bus.Err),    e);
  endtask

  // Control rises before edge k; Valid must be low at k+2, high at k+3, low at k+4.
  task automatic capture(input string tag, input int x, input int y, input int m);
    bus.X = 8'(x); bus.Y = 8'(y); bus.M = 4'(m);
    bus.Control = 1'b1;
    tick();                      // edge k
    tick();                      // edge k+1
    tick();                      // edge k+2
    check({tag, "_valid_k2"}, 32'(bus.Valid), 0);
    tick();                      // edge k+3
    check({tag, "_valid_k3"}, 32'(bus.Valid), 1);
    check_result(tag, x, y, m);
    tick();                      // edge k+4
    check({tag, "_valid_k4"}, 32'(bus.Valid), 0);
    bus.Control = 1'b0;
    tick();
    tick();
  endtask

  // Lock onto a frame start, then check all DIGITS*RDIV cycles of the frame.
  task automatic check_frame(input string tag, input logic [15:0] src);
    logic [7:0] prev;
    logic [7:0] exp_an;
    logic [6:0] exp_led;
    bit         found;
    int         d;
    prev  = bus.Anode_Activate;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (prev == 8'h7F && bus.Anode_Activate == 8'hFE) found = 1'b1;
      else prev = bus.Anode_Activate;
    end
    check({tag, "_sync"}, 32'(found), 1);
    if (found) begin
      for (int cyc = 0; cyc < DIGITS * RDIV; cyc++) begin
        d       = cyc / RDIV;
        exp_an  = ~(8'd1 << d);
        exp_led = (d < 4) ? FONT[(src >> (4 * d)) & 16'hF] : 7'h7F;
        check({tag, "_anode"}, 32'(bus.Anode_Activate), 32'(exp_an));
        check({tag, "_led"},   32'(bus.LED_out),        32'(exp_led));
        if (cyc != DIGITS * RDIV - 1) tick();
      end
    end
  endtask

  initial begin
    int vcount;
    int x0, y0, m0;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.X = '0; bus.Y = '0; bus.M = '0;
    bus.Control = 1'b0; bus.Disp_sel = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_result", 32'(bus.Result), 0);
    check("rst_carry",  32'(bus.Carry), 0);
    check("rst_zero",   32'(bus.Zero), 0);
    check("rst_err",    32'(bus.Err), 0);
    check("rst_valid",  32'(bus.Valid), 0);
    check("rst_anode",  32'(bus.Anode_Activate), 32'hFF);
    check("rst_led",    32'(bus.LED_out), 32'h7F);

    // First display release: digit 0 for RDIV edges, then digit 1
    rst_n = 1'b1;
    tick();
    check("rel1_anode", 32'(bus.Anode_Activate), 32'hFE);
    check("rel1_led",   32'(bus.LED_out), 32'(FONT[0]));
    tick(); tick(); tick();
    check("rel4_anode", 32'(bus.Anode_Activate), 32'hFE);
    tick();
    check("rel5_anode", 32'(bus.Anode_Activate), 32'hFD);

    // Directed operations
    capture("add_ovf", 8'hFF, 8'h01, 0);
    capture("sub_brw", 8'h05, 8'h07, 1);
    capture("mul_max", 8'hFF, 8'hFF, 2);
    capture("bad_op",  8'h5A, 8'hA5, 12);
    capture("and_zero", 8'hF0, 8'h0F, 3);
    capture("shl", 8'h81, 8'h09, 7);
    capture("shr", 8'h80, 8'h07, 8);
    capture("cmp_eq", 8'h33, 8'h33, 9);

    // Randomised operations against the reference model
    for (int i = 0; i < 40; i++)
      capture("rand", $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15));

    // Control held high while X wanders: exactly one capture of the first X
    x0 = $urandom_range(0, 255); y0 = $urandom_range(0, 255); m0 = 0;
    bus.X = 8'(x0); bus.Y = 8'(y0); bus.M = 4'(m0);
    bus.Control = 1'b1;
    vcount = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.Valid) vcount++;
      if (i >= 2) bus.X = 8'($urandom_range(0, 255));
    end
    check("hold_valid_cnt", vcount, 1);
    check_result("hold", x0, y0, m0);
    bus.Control = 1'b0;
    tick(); tick();

    // High/low/high gives two captures
    capture("twice_a", 8'h10, 8'h20, 4);
    capture("twice_b", 8'h0F, 8'h03, 5);

    // Scan of Result = 0x00A3
    capture("scan_res", 8'hA0, 8'h03, 0);
    check_frame("scan_res", 16'h00A3);

    // Scan of captured operands
    capture("scan_ops", 8'h12, 8'h34, 3);
    bus.Disp_sel = 1'b1;
    tick();
    check_frame("scan_ops", 16'h1234);
    bus.Disp_sel = 1'b0;

    // Reset at edge k+2 of a capture
    bus.X = 8'hFF; bus.Y = 8'h01; bus.M = 4'd0;
    bus.Control = 1'b1;
    tick();                      // edge k
    tick();                      // edge k+1
    rst_n = 1'b0;
    bus.Control = 1'b0;
    tick();                      // edge k+2 under reset
    check("mid_rst_result", 32'(bus.Result), 0);
    check("mid_rst_anode",  32'(bus.Anode_Activate), 32'hFF);
    check("mid_rst_led",    32'(bus.LED_out), 32'h7F);
    check("mid_rst_valid",  32'(bus.Valid), 0);
    tick();                      // edge k+3 under reset
    check("mid_rst_valid_k3", 32'(bus.Valid), 0);
    rst_n = 1'b1;
    tick();
    check("mid_rel_anode", 32'(bus.Anode_Activate), 32'hFE);
    check("mid_rel_led",   32'(bus.LED_out), 32'(FONT[0]));
    check("mid_rel_valid", 32'(bus.Valid), 0);
    tick();
    check("mid_rel_valid2", 32'(bus.Valid), 0);
    check("mid_rel_result", 32'(bus.Result), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_display_ctrl.md
# alu_display_ctrl

Parametrised ALU with registered result and a time-multiplexed N-digit hex 7-segment driver, replacing the fixed 4-bit ALU/decoder/display block in the lab calculator. Operands and opcode come from switches. A debounced-level `Control` strobe captures them. The result is computed and held in a register, then scanned continuously onto a common-anode display, with either the result or the operands shown.

## Interface
- `WIDTH`, default 8: operand width in bits, a multiple of 4 with WIDTH >= 4. The result width is RW = 2*WIDTH.
- `DIGITS`, default 8: number of display digits. Requires DIGITS*4 >= RW and DIGITS >= 2.
- `REFRESH_DIV`, default 100000: clock cycles per digit (1 ms at 100 MHz). Requires REFRESH_DIV >= 2.
- `clock_100Mhz` in, 1: the single clock; all logic is on the rising edge.
- `reset` in, 1: synchronous, active-low reset.
- `X` in, WIDTH: operand A.
- `Y` in, WIDTH: operand B.
- `M` in, 4: opcode.
- `Control` in, 1: capture strobe, asynchronous to the clock (switch or button).
- `Disp_sel` in, 1: 0 shows Result; 1 shows the captured {X,Y}, with Y on the low digits.
- `Result` out, RW: registered ALU result.
- `Carry` out, 1: carry or borrow flag.
- `Zero` out, 1: high when Result == 0.
- `Err` out, 1: high when the captured opcode is unsupported.
- `Valid` out, 1: one-cycle pulse when Result updates.
- `Anode_Activate` out, DIGITS: active-low digit enables, one-cold.
- `LED_out` out, 7: active-low segments, bit6 = a through bit0 = g.

## Operation
- `Control` passes through a 2-flop synchroniser, then a rising-edge detector.
- A detected edge latches X, Y and M into internal operand registers. The ALU then evaluates the latched values.
- Holding `Control` high produces exactly one capture. A new capture requires `Control` to go low and then high again.
- Opcodes. Results are zero-extended to RW, and Carry = 0 unless stated otherwise.
  - 0 ADD: X+Y. Carry = bit WIDTH of the sum.
  - 1 SUB: (X-Y) mod 2^WIDTH. Carry = 1 if X < Y (borrow).
  - 2 MUL: X*Y, full RW bits.
  - 3 AND, 4 OR, 5 XOR.
  - 6 NOT: ~X, low WIDTH bits.
  - 7 SHL: X << Y[log2(WIDTH)-1:0], truncated to WIDTH bits.
  - 8 SHR: logical right shift, same shift-amount rule as SHL.
  - 9 CMP: Result = {X<Y, X==Y, X>Y} in bits 2:0.
  - 10 to 15: Result = 0, Err = 1, Carry = 0.
- Zero is derived from the new Result at the same clock edge that Result updates.
- Result, Carry, Zero and Err hold their values until the next capture.
- Display scan:
  - A prescaler counts 0 to REFRESH_DIV-1. At its wrap, the digit index advances 0 → DIGITS-1 → 0.
  - Digit i shows nibble i of the selected source. Nibbles beyond the source width are blanked (all segments off).
  - Font (a..g): 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- `Anode_Activate` and `LED_out` are registered together so there is no ghosting. Only bit `idx` of Anode_Activate is low.

## Timing
- Reset (`reset` = 0 at an edge) forces:
  - Result = 0; Carry, Zero, Err and Valid = 0.
  - Operand registers and synchroniser = 0.
  - Prescaler = 0, digit index = 0.
  - Anode_Activate = all 1s and LED_out = 7'h7F (display dark).
- Reset overrides everything. A capture in flight is lost, and Valid does not pulse.
- Capture latency: `Control` first sampled high at edge k, having been low at edge k-1:
  - Operands are latched at edge k+2.
  - Result and flags are updated, and Valid is high, at edge k+3. Valid is high for one cycle only.
- A `Control` pulse shorter than one clock period may be missed. Bounce or debouncing is external.
- Display pipeline:
  - The first release after reset is at edge 1. Anode_Activate = ~1 (digit 0 enabled), and LED_out shows nibble 0.
  - Digit changes occur one edge after a prescaler wrap.
  - The digit period is REFRESH_DIV cycles, and the frame period is DIGITS*REFRESH_DIV cycles.
- Result update mid-frame: the new value appears on the next registered display update. The frame does not restart.
- A `Disp_sel` change takes effect on the next registered display update.

## Test plan
- ADD, WIDTH=8: X=0xFF, Y=0x01, M=0, Control pulse → Result=0x0100, Carry=1, Zero=0, Valid high for 1 cycle at edge k+3.
- SUB and MUL: X=0x05, Y=0x07, M=1 → Result=0x00FE, Carry=1. Then X=0xFF, Y=0xFF, M=2 → Result=0xFE01, Carry=0.
- Invalid opcode, then Zero: M=12 → Result=0, Err=1, Zero=1. Then M=3 with X=0xF0, Y=0x0F → Result=0, Zero=1, Err=0.
- Strobe handling: Control held high for 50 cycles while X changes → exactly one Valid pulse and one capture. Control high/low/high → two captures.
- Scan, REFRESH_DIV=4, Result=0x00A3, Disp_sel=0:
  - Anode_Activate walks 0xFE → 0xFD → … → 0x7F, 4 cycles per digit, 32-cycle frame.
  - Digit 0 shows 0000110, digit 1 shows 0001000, digits 2 and 3 show 0000001, digits 4 to 7 show 1111111.
  - Disp_sel=1 with X=0x12, Y=0x34 → digits 0 to 3 show 4, 3, 2, 1.
- Reset mid-operation: assert reset at edge k+2 of a capture → no Valid pulse, Result=0, Anode_Activate=0xFF, LED_out=0x7F. The scan restarts at digit 0 on the first edge after release.
